// File: rtl/noc_boundary_injector.sv
// Boundary-router flit injector: buffers source flits, frames packets from the header length
// and spends downstream credits. Define NOC_INJECTOR_DEST_CHECK_EN to drop on-chip headers with bad x/y.
module noc_boundary_injector #(
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 4,
    parameter int X_TILES    = 1,
    parameter int Y_TILES    = 1,
    parameter int CHIP_ID    = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [63:0]                  src_data,
    input  logic                         src_val,
    output logic                         src_rdy,
    output logic [63:0]                  noc_data_out,
    output logic                         noc_valid_out,
    input  logic                         noc_yummy_in,
    output logic [$clog2(CREDITS+1)-1:0] credits,
    output logic                         in_packet,
    output logic [31:0]                  pkt_count,
    output logic                         credit_err
`ifdef NOC_INJECTOR_DEST_CHECK_EN
    ,
    output logic                         dest_err
`endif
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
    localparam logic [OW-1:0] FIFO_FULL = OW'(FIFO_DEPTH);

`ifdef NOC_INJECTOR_DEST_CHECK_EN
    typedef enum logic [1:0] { ST_HEAD, ST_BODY, ST_DROP } state_e;
`else
    typedef enum logic [1:0] { ST_HEAD, ST_BODY } state_e;
`endif

    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wrPtr_q, rdPtr_q;
    logic [OW-1:0] occ_q, occ_d;
    state_e        state_q, state_d;
    logic [7:0]    remaining_q, remaining_d;
    logic          inPacket_q, inPacket_d;
    logic [31:0]   pktCount_q, pktCount_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          creditErr_q, creditErr_d;
    logic          nocValid_q;
    logic [63:0]   nocData_q;

    logic          fifoEmpty, push, pop, doSend, doDrop;
    logic [63:0]   headFlit;
    logic [7:0]    headLen;

    assign fifoEmpty = (occ_q == '0);
    assign src_rdy   = (occ_q != FIFO_FULL);
    assign push      = src_val && src_rdy;
    assign pop       = doSend || doDrop;
    assign headFlit  = mem_q[rdPtr_q];
    assign headLen   = headFlit[29:22];

`ifdef NOC_INJECTOR_DEST_CHECK_EN
    logic [13:0] headChip;
    logic [7:0]  headX, headY;
    logic        headIllegal, dropHeader, destErr_q;

    assign headChip    = headFlit[63:50];
    assign headX       = headFlit[49:42];
    assign headY       = headFlit[41:34];
    assign headIllegal = (headChip == 14'(CHIP_ID)) &&
                         ((int'(headX) >= X_TILES) || (int'(headY) >= Y_TILES));
    assign dropHeader  = doDrop && (state_q == ST_HEAD);
    assign dest_err    = destErr_q;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        inPacket_d  = inPacket_q;
        pktCount_d  = pktCount_q;
        doSend      = 1'b0;
        doDrop      = 1'b0;
        case (state_q)
            ST_HEAD: begin
                if (!fifoEmpty) begin
`ifdef NOC_INJECTOR_DEST_CHECK_EN
                    if (headIllegal) begin
                        doDrop = 1'b1;
                        if (headLen != 8'd0) begin
                            remaining_d = headLen;
                            state_d     = ST_DROP;
                        end
                    end else
`endif
                    if (credits_q != '0) begin
                        doSend = 1'b1;
                        if (headLen == 8'd0) begin
                            pktCount_d = pktCount_q + 32'd1;
                        end else begin
                            remaining_d = headLen;
                            inPacket_d  = 1'b1;
                            state_d     = ST_BODY;
                        end
                    end
                end
            end
            ST_BODY: begin
                if (!fifoEmpty && (credits_q != '0)) begin
                    doSend      = 1'b1;
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        pktCount_d = pktCount_q + 32'd1;
                        inPacket_d = 1'b0;
                        state_d    = ST_HEAD;
                    end
                end
            end
`ifdef NOC_INJECTOR_DEST_CHECK_EN
            // Dropped body flits drain at one per cycle without touching credits.
            ST_DROP: begin
                if (!fifoEmpty) begin
                    doDrop      = 1'b1;
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) state_d = ST_HEAD;
                end
            end
`endif
            default: state_d = ST_HEAD;
        endcase
    end

    // A send and a returned credit in the same cycle cancel out.
    always_comb begin
        credits_d   = credits_q;
        creditErr_d = creditErr_q;
        if (doSend && !noc_yummy_in) begin
            credits_d = credits_q - 1'b1;
        end else if (!doSend && noc_yummy_in) begin
            if (credits_q == CRED_MAX) creditErr_d = 1'b1;
            else                       credits_d   = credits_q + 1'b1;
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (push && !pop)      occ_d = occ_q + 1'b1;
        else if (!push && pop) occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= src_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            occ_q       <= '0;
            state_q     <= ST_HEAD;
            remaining_q <= 8'd0;
            inPacket_q  <= 1'b0;
            pktCount_q  <= 32'd0;
            credits_q   <= CRED_MAX;
            creditErr_q <= 1'b0;
            nocValid_q  <= 1'b0;
            nocData_q   <= 64'd0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
            occ_q       <= occ_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            inPacket_q  <= inPacket_d;
            pktCount_q  <= pktCount_d;
            credits_q   <= credits_d;
            creditErr_q <= creditErr_d;
            nocValid_q  <= doSend;
            if (doSend) nocData_q <= headFlit;
        end
    end

`ifdef NOC_INJECTOR_DEST_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          destErr_q <= 1'b0;
        else if (dropHeader) destErr_q <= 1'b1;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && dropHeader)
            $display("noc_boundary_injector: illegal destination x=%0d y=%0d", headX, headY);
    end
`endif
`endif

    assign noc_valid_out = nocValid_q;
    assign noc_data_out  = nocData_q;
    assign credits       = credits_q;
    assign in_packet     = inPacket_q;
    assign pkt_count     = pktCount_q;
    assign credit_err    = creditErr_q;

endmodule

// File: tb/tb_noc_boundary_injector.sv
// Self-checking bench for noc_boundary_injector: a constant vector table, hand-written corner
// sequences and randomized traffic compared against a flit-queue reference model.
module tb_noc_boundary_injector;
    localparam int FIFO_DEPTH = 4;
    localparam int CREDITS    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] srcData = '0;
    logic        srcVal = 1'b0;
    logic        srcRdy;
    logic [63:0] nocData;
    logic        nocValid;
    logic        yummy = 1'b0;
    logic [2:0]  creditsOut;
    logic        inPacket;
    logic [31:0] pktCount;
    logic        creditErr;
`ifdef NOC_INJECTOR_DEST_CHECK_EN
    logic        destErr;
`endif

    noc_boundary_injector #(
        .FIFO_DEPTH(FIFO_DEPTH), .CREDITS(CREDITS), .X_TILES(1), .Y_TILES(1), .CHIP_ID(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_data(srcData), .src_val(srcVal), .src_rdy(srcRdy),
        .noc_data_out(nocData), .noc_valid_out(nocValid), .noc_yummy_in(yummy),
        .credits(creditsOut), .in_packet(inPacket), .pkt_count(pktCount),
        .credit_err(creditErr)
`ifdef NOC_INJECTOR_DEST_CHECK_EN
        , .dest_err(destErr)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a flit queue, a credit counter and a count of body flits still owed.
    logic [63:0] mFifo[$];
    int          mCredits, mOwed, mDropOwed, routerHeld;
    logic [31:0] mPkt;
    logic        mValid, mErr, mDestErr;
    logic [63:0] mData;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mkHdr(input logic [13:0] chip, input logic [7:0] x,
                                          input logic [7:0] y, input logic [7:0] len);
        return {chip, x, y, 4'h0, len, 22'h0A5A5};
    endfunction

    function automatic logic [63:0] mkRand();
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[29:22] = ($urandom_range(0, 59) == 0) ? 8'd255 : 8'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) f[63:42] = {14'd0, 7'd0, 1'($urandom_range(0, 1))};
        return f;
    endfunction

`ifdef NOC_INJECTOR_DEST_CHECK_EN
    function automatic bit isIllegal(input logic [63:0] f);
        return (f[63:50] == 14'd0) && ((f[49:42] >= 8'd1) || (f[41:34] >= 8'd1));
    endfunction
`endif

    task automatic modelReset();
        mFifo.delete();
        mCredits = CREDITS; mOwed = 0; mDropOwed = 0; routerHeld = 0;
        mPkt = '0; mValid = 0; mErr = 0; mDestErr = 0; mData = '0;
    endtask

    task automatic modelStep(input logic v, input logic [63:0] d, input logic y);
        bit rdy, snd;
        logic [63:0] f;
        rdy = (mFifo.size() < FIFO_DEPTH);
        snd = 0;
        f = '0;
        if (mFifo.size() > 0) begin
`ifdef NOC_INJECTOR_DEST_CHECK_EN
            if (mDropOwed > 0) begin
                void'(mFifo.pop_front());
                mDropOwed--;
            end else if (mOwed == 0 && isIllegal(mFifo[0])) begin
                f = mFifo.pop_front();
                mDestErr = 1;
                mDropOwed = int'(f[29:22]);
            end else
`endif
            if (mCredits > 0) begin
                snd = 1;
                f = mFifo.pop_front();
            end
        end
        mValid = snd;
        if (snd) begin
            mData = f;
            routerHeld++;
            if (mOwed == 0) begin
                if (f[29:22] == 8'd0) mPkt = mPkt + 1;
                else                  mOwed = int'(f[29:22]);
            end else begin
                mOwed--;
                if (mOwed == 0) mPkt = mPkt + 1;
            end
        end
        if (y && routerHeld > 0) routerHeld--;
        if (snd && !y) mCredits--;
        else if (!snd && y) begin
            if (mCredits == CREDITS) mErr = 1;
            else                     mCredits++;
        end
        if (v && rdy) mFifo.push_back(d);
    endtask

    task automatic checkOutput();
        check("src_rdy", srcRdy, (mFifo.size() < FIFO_DEPTH));
        check("noc_valid", nocValid, mValid);
        check("noc_data", nocData, mData);
        check("credits", creditsOut, mCredits);
        check("in_packet", inPacket, (mOwed != 0));
        check("pkt_count", pktCount, mPkt);
        check("credit_err", creditErr, mErr);
`ifdef NOC_INJECTOR_DEST_CHECK_EN
        check("dest_err", destErr, mDestErr);
`endif
    endtask

    // Called at a falling edge; drives one cycle of inputs and checks the result one edge later.
    task automatic applyStimulus(input logic v, input logic [63:0] d, input logic y);
        srcVal = v; srcData = d; yummy = y;
        @(posedge clk);
        modelStep(v, d, y);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doReset();
        rst_n = 1'b0; srcVal = 1'b0; yummy = 1'b0;
        #1;
        check("rst_async_valid", nocValid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", nocValid, 1'b0);
        check("rst_data", nocData, 64'd0);
        check("rst_credits", creditsOut, CREDITS);
        check("rst_in_packet", inPacket, 1'b0);
        check("rst_pkt_count", pktCount, 32'd0);
        check("rst_credit_err", creditErr, 1'b0);
        check("rst_src_rdy", srcRdy, 1'b1);
        modelReset();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        y;
        logic        eValid;
        logic [63:0] eData;
        int          eCredits;
        logic        eInPkt;
        int          ePkt;
    } vec_t;

    initial begin
        vec_t tbl[5];
        logic [63:0] hdr2;
        logic        ry;

        modelReset();
        @(negedge clk);
        doReset();

        // Header length 2 plus two body flits, no credits returned.
        hdr2 = mkHdr(14'd0, 8'd0, 8'd0, 8'd2);
        tbl[0] = '{1'b1, hdr2,                  1'b0, 1'b0, 64'd0,                 4, 1'b0, 0};
        tbl[1] = '{1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b1, hdr2,                  3, 1'b1, 0};
        tbl[2] = '{1'b1, 64'hDEAD_BEEF_0000_0002, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 2, 1'b1, 0};
        tbl[3] = '{1'b0, 64'd0,                 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0002, 1, 1'b0, 1};
        tbl[4] = '{1'b0, 64'd0,                 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0002, 1, 1'b0, 1};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(tbl[i].v, tbl[i].d, tbl[i].y);
            check($sformatf("tbl%0d_valid", i), nocValid, tbl[i].eValid);
            check($sformatf("tbl%0d_data", i), nocData, tbl[i].eData);
            check($sformatf("tbl%0d_credits", i), creditsOut, tbl[i].eCredits);
            check($sformatf("tbl%0d_in_packet", i), inPacket, tbl[i].eInPkt);
            check($sformatf("tbl%0d_pkt_count", i), pktCount, tbl[i].ePkt);
        end

        // Six single-flit packets against four credits, then two credits back.
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, mkHdr(14'd0, 8'd0, 8'd0, 8'd0) | 64'(i), 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 64'd0, 1'b0);
        check("starve_credits", creditsOut, 0);
        check("starve_pkt_count", pktCount, 4);
        check("starve_src_rdy", srcRdy, 1'b1);
        applyStimulus(1'b0, 64'd0, 1'b1);
        applyStimulus(1'b0, 64'd0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 64'd0, 1'b0);
        check("refill_credits", creditsOut, 0);
        check("refill_pkt_count", pktCount, 6);

        // Send and yummy together at credits=2, then overflow the credit counter.
        applyStimulus(1'b0, 64'd0, 1'b1);
        applyStimulus(1'b0, 64'd0, 1'b1);
        applyStimulus(1'b1, mkHdr(14'd0, 8'd0, 8'd0, 8'd0), 1'b0);
        check("pre_cancel_credits", creditsOut, 2);
        applyStimulus(1'b0, 64'd0, 1'b1);
        check("cancel_valid", nocValid, 1'b1);
        check("cancel_credits", creditsOut, 2);
        applyStimulus(1'b0, 64'd0, 1'b1);
        applyStimulus(1'b0, 64'd0, 1'b1);
        applyStimulus(1'b0, 64'd0, 1'b1);
        check("ovf_credits", creditsOut, 4);
        check("ovf_credit_err", creditErr, 1'b1);
        applyStimulus(1'b1, mkHdr(14'd0, 8'd0, 8'd0, 8'd0), 1'b0);
        applyStimulus(1'b0, 64'd0, 1'b0);
        applyStimulus(1'b0, 64'd0, 1'b1);
        check("sticky_credit_err", creditErr, 1'b1);

        // Full FIFO at zero credits refuses a fifth flit.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, mkHdr(14'd0, 8'd0, 8'd0, 8'd0), 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 64'h1111_0000_0000_0000 | 64'(i), 1'b0);
        check("full_src_rdy", srcRdy, 1'b0);
        applyStimulus(1'b1, 64'h2222_0000_0000_0000, 1'b0);
        check("full_reject_src_rdy", srcRdy, 1'b0);
        applyStimulus(1'b0, 64'd0, 1'b1);
        applyStimulus(1'b0, 64'd0, 1'b0);
        check("drain_valid", nocValid, 1'b1);
        check("drain_data", nocData, 64'h1111_0000_0000_0000);
        check("drain_src_rdy", srcRdy, 1'b1);

        // Reset in the middle of a 4-flit packet; the next flit is a fresh header.
        doReset();
        applyStimulus(1'b1, mkHdr(14'd0, 8'd0, 8'd0, 8'd3), 1'b0);
        applyStimulus(1'b1, 64'hB0D1, 1'b0);
        applyStimulus(1'b1, 64'hB0D2, 1'b0);
        check("mid_in_packet", inPacket, 1'b1);
        doReset();
        applyStimulus(1'b1, mkHdr(14'd0, 8'd0, 8'd0, 8'd0), 1'b0);
        applyStimulus(1'b0, 64'd0, 1'b0);
        applyStimulus(1'b0, 64'd0, 1'b0);
        check("post_rst_pkt_count", pktCount, 1);

`ifdef NOC_INJECTOR_DEST_CHECK_EN
        // Illegal on-chip destination is dropped with its body.
        doReset();
        applyStimulus(1'b1, mkHdr(14'd0, 8'd1, 8'd0, 8'd1), 1'b0);
        applyStimulus(1'b1, 64'hBAD0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 64'd0, 1'b0);
            check("drop_valid", nocValid, 1'b0);
        end
        check("drop_dest_err", destErr, 1'b1);
        check("drop_credits", creditsOut, 4);
        applyStimulus(1'b1, mkHdr(14'd0, 8'd0, 8'd0, 8'd0), 1'b0);
        applyStimulus(1'b0, 64'd0, 1'b0);
        check("after_drop_pkt_count", pktCount, 1);
`endif

        // Randomized traffic; credits return only for flits the router actually holds.
        doReset();
        for (int i = 0; i < 1500; i++) begin
            ry = (routerHeld > 0) && ($urandom_range(0, 2) != 0);
            applyStimulus($urandom_range(0, 9) < 7, mkRand(), ry);
        end
        for (int i = 0; i < 400; i++) applyStimulus(1'b0, 64'd0, routerHeld > 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
